regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 17 +
 rtl/regfile_mp.sv | 77 +++++++
 tb/tb_regfile_mp.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: packed read/write ports plus clear-complete flag.
interface regfile_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR         = 2,
  parameter int NW         = 1
);
  logic [NR*ADDR_WIDTH-1:0] raddr;
  logic [NR*DATA_WIDTH-1:0] rdata;
  logic [NW-1:0]            wen;
  logic [NW*ADDR_WIDTH-1:0] waddr;
  logic [NW*DATA_WIDTH-1:0] wdata;
  logic                     init_done;

  modport master (output raddr, wen, waddr, wdata, input rdata, init_done);
  modport slave  (input raddr, wen, waddr, wdata, output rdata, init_done);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file, entry 0 hardwired to zero, with a post-reset clear sequencer.
// Optional REGFILE_BYPASS_EN: same-edge write-to-read forwarding (write-first reads).
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR         = 2,
  parameter int NW         = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [NR-1:0][DATA_WIDTH-1:0] r_rdata;

  logic [NR-1:0][ADDR_WIDTH-1:0] w_raddr;
  logic [NW-1:0][ADDR_WIDTH-1:0] w_waddr;
  logic [NW-1:0][DATA_WIDTH-1:0] w_wdata;

  assign w_raddr = bus.raddr;
  assign w_waddr = bus.waddr;
  assign w_wdata = bus.wdata;
  assign bus.rdata     = r_rdata;
  assign bus.init_done = r_init_done;

  // Counter starts at 1: entry 0 is never stored, reads of it are forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= ADDR_WIDTH'(1);
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) begin
        r_state     <= S_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  // Array has no reset; the INIT sweep clears it. Later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (bus.wen[j] && w_waddr[j] != '0)
          r_mem[w_waddr[j]] <= w_wdata[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (r_state == S_INIT || w_raddr[i] == '0) begin
          r_rdata[i] <= '0;
        end else begin
          r_rdata[i] <= r_mem[w_raddr[i]];
`ifdef REGFILE_BYPASS_EN
          for (int j = 0; j < NW; j++)
            if (bus.wen[j] && w_waddr[j] == w_raddr[i])
              r_rdata[i] <= w_wdata[j];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (AW=5, DW=32, NR=2, NW=2).
module tb_regfile_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic set_wr(input logic [NW-1:0] en, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.wen   = en;
    bus.waddr = {a1, a0};
    bus.wdata = {d1, d0};
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_rd(0, 0);
    set_wr(2'b00, 0, 0, 0, 0);
    step();
    step();
    chk("reset_rdata0", rd(0), 32'h0);
    chk("reset_rdata1", rd(1), 32'h0);
    chk("reset_init_done", {31'b0, bus.init_done}, 32'h0);
    rst = 1'b0;

    // Clear sequence with a write pulsed in cycle 10 that must be lost.
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) set_wr(2'b01, 5'd4, 32'h77, 0, 0);
      step();
      if (k == 10) set_wr(2'b00, 0, 0, 0, 0);
      chk($sformatf("clear_init_done_edge%0d", k), {31'b0, bus.init_done}, (k == 31) ? 32'h1 : 32'h0);
    end

    for (int a = 0; a < 16; a++) begin
      set_rd(AW'(a), AW'(a + 16));
      step();
      chk($sformatf("cleared_addr%0d", a), rd(0), 32'h0);
      chk($sformatf("cleared_addr%0d", a + 16), rd(1), 32'h0);
    end
    set_rd(5'd4, 5'd0);
    step();
    chk("init_write_dropped", rd(0), 32'h0);

    // Basic write/read
    set_wr(2'b01, 5'd7, 32'hDEADBEEF, 0, 0);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(5'd7, 5'd0);
    step();
    chk("basic_rdata0", rd(0), 32'hDEADBEEF);
    chk("basic_rdata1_zero", rd(1), 32'h0);

    // Port collision, then write to address 0
    set_wr(2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
    step();
    set_wr(2'b01, 5'd0, 32'h55, 0, 0);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(5'd3, 5'd0);
    step();
    chk("collision_high_port_wins", rd(0), 32'h22);
    chk("addr0_write_dropped", rd(1), 32'h0);

    // Same-cycle forwarding
    set_wr(2'b01, 5'd9, 32'hA, 0, 0);
    step();
    set_wr(2'b01, 5'd9, 32'hB, 0, 0);
    set_rd(5'd9, 5'd7);
    step();
`ifdef REGFILE_BYPASS_EN
    chk("fwd_same_edge", rd(0), 32'hB);
`else
    chk("fwd_same_edge", rd(0), 32'hA);
`endif
    chk("fwd_other_port", rd(1), 32'hDEADBEEF);
    set_wr(2'b00, 0, 0, 0, 0);
    step();
    chk("fwd_next_cycle", rd(0), 32'hB);

    // Mid-operation reset
    set_wr(2'b10, 0, 0, 5'd31, 32'h1234);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(5'd31, 5'd3);
    step();
    chk("pre_reset_addr31", rd(0), 32'h1234);
    rst = 1'b1;
    #1;
    chk("midrst_rdata0", rd(0), 32'h0);
    chk("midrst_rdata1", rd(1), 32'h0);
    chk("midrst_init_done", {31'b0, bus.init_done}, 32'h0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 5) chk("init_rdata_forced_zero", rd(0), 32'h0);
      if (k >= 30)
        chk($sformatf("reclear_init_done_edge%0d", k), {31'b0, bus.init_done}, (k == 31) ? 32'h1 : 32'h0);
    end
    step();
    chk("reclear_addr31", rd(0), 32'h0);
    chk("reclear_addr3", rd(1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
